// File: rtl/miriscv_lsu.sv
// Load-store unit: runs a req/gnt/rvalid bus transaction per memory op, stalls the core meanwhile,
// formats store byte enables/data and aligns/extends load data for the register file.
module miriscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_valid_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state;
  logic          req_q, we_q;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   addr_q, wdata_q, data_q;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt;

  logic        size_ok, align_ok, legal, accept, done, timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, rsh, ext;
  logic [15:0] half;

  always_comb begin
    size_ok = 1'b1;
    case (lsu_size_i)
      3'b011, 3'b110, 3'b111: size_ok = 1'b0;
      default:                size_ok = 1'b1;
    endcase
    align_ok = !((lsu_size_i[1:0] == 2'b10 && lsu_addr_i[1:0] != 2'b00) ||
                 (lsu_size_i[1:0] == 2'b01 && lsu_addr_i[0]));
    legal    = size_ok & align_ok;
  end

  // Store lanes are replicated so the addressed byte/half lands under its enable.
  always_comb begin
    case (lsu_size_i[1:0])
      2'b00: begin
        be_n    = 4'b0001 << lsu_addr_i[1:0];
        wdata_n = {4{lsu_data_i[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << lsu_addr_i[1:0];
        wdata_n = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = lsu_data_i;
      end
    endcase
  end

  always_comb begin
    rsh  = data_rdata_i >> {off_q, 3'b000};
    half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q[1:0])
      2'b00:   ext = {{24{~size_q[2] & rsh[7]}}, rsh[7:0]};
      2'b01:   ext = {{16{~size_q[2] & half[15]}}, half};
      default: ext = data_rdata_i;
    endcase
  end

  assign accept  = (state == IDLE) & lsu_req_i & legal;
  assign done    = (state == RESP) & data_rvalid_i;
  assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1)) && !done;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt     <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state   <= REQ;
          req_q   <= 1'b1;
          we_q    <= lsu_we_i;
          size_q  <= lsu_size_i;
          off_q   <= lsu_addr_i[1:0];
          addr_q  <= {lsu_addr_i[31:2], 2'b00};
          be_q    <= be_n;
          wdata_q <= wdata_n;
          cnt     <= '0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            state <= IDLE;
            req_q <= 1'b0;
          end else if (data_gnt_i) begin
            state <= RESP;
            req_q <= 1'b0;
          end
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          if (done || timeout) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
      if (lsu_valid_o) data_q <= ext;
    end
  end

  assign lsu_stall_req_o = ~reset & (accept |
                           (((state == REQ) | ((state == RESP) & ~data_rvalid_i)) & ~timeout));
  assign lsu_err_o    = ~reset & (((state == IDLE) & lsu_req_i & ~legal) | timeout);
  assign lsu_valid_o  = done & ~we_q;
  assign lsu_data_o   = lsu_valid_o ? ext : data_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: loads, stores, illegal accesses, bus delays, timeout, reset.
module tb_miriscv_lsu;
  logic        clk_i = 1'b0, reset = 1'b1;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = '0;
  logic [31:0] lsu_addr_i = '0, lsu_data_i = '0;
  logic        lsu_stall_req_o, lsu_valid_o, lsu_err_o;
  logic [31:0] lsu_data_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int vec = 0, miss = 0;

  typedef struct {
    int          req, stall, valid;
    logic        err, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, dat, after;
  } obs_t;

  miriscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset(reset),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
    .lsu_valid_o(lsu_valid_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Bus model: grant after gd REQ cycles, rvalid after rd RESP wait cycles; records what it saw.
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr, wd,
                         input int gd, rd, input logic [31:0] rdata, output obs_t o);
    int n;
    o = '{default: '0};
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wd;
    #1;
    o.stall += int'(lsu_stall_req_o); o.err |= lsu_err_o;
    step();
    n = 0;
    while (data_req_o && n < 40) begin
      data_gnt_i = (n == gd);
      #1;
      o.req++; o.stall += int'(lsu_stall_req_o); o.err |= lsu_err_o;
      o.be = data_be_o; o.addr = data_addr_o; o.wdata = data_wdata_o; o.we = data_we_o;
      step();
      data_gnt_i = 1'b0;
      n++;
    end
    n = 0;
    while (n <= rd && n < 40) begin
      data_rvalid_i = (n == rd); data_rdata_i = rdata;
      #1;
      o.stall += int'(lsu_stall_req_o); o.valid += int'(lsu_valid_o); o.err |= lsu_err_o;
      if (data_rvalid_i) o.dat = lsu_data_o;
      step();
      n++;
    end
    data_rvalid_i = 1'b0; lsu_req_i = 1'b0;
    #1;
    o.after = lsu_data_o; o.valid += int'(lsu_valid_o);
  endtask

  task automatic test_reset();
    reset = 1'b1; lsu_req_i = 1'b1; lsu_size_i = 3'b011;
    #2;
    vec++; if (lsu_err_o !== 1'b0 || lsu_stall_req_o !== 1'b0) begin
      miss++; $display("FAIL reset_err_stall got err=%b stall=%b exp 0 0", lsu_err_o, lsu_stall_req_o); end
    vec++; if (data_req_o !== 1'b0 || lsu_valid_o !== 1'b0 || lsu_data_o !== 32'h0 || data_be_o !== 4'h0) begin
      miss++; $display("FAIL reset_outputs got req=%b valid=%b data=%h be=%h exp zeros",
                       data_req_o, lsu_valid_o, lsu_data_o, data_be_o); end
    lsu_req_i = 1'b0; lsu_size_i = 3'b000;
    step(); reset = 1'b0; step();
  endtask

  task automatic test_lw();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, o);
    vec++; if (o.stall != 2 || o.req != 1) begin
      miss++; $display("FAIL lw_timing got stall=%0d req=%0d exp 2 1", o.stall, o.req); end
    vec++; if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b0) begin
      miss++; $display("FAIL lw_bus got addr=%h be=%h we=%b exp 100 f 0", o.addr, o.be, o.we); end
    vec++; if (o.valid != 1 || o.dat !== 32'hDEADBEEF || o.err !== 1'b0) begin
      miss++; $display("FAIL lw_data got valid=%0d data=%h err=%b exp 1 deadbeef 0", o.valid, o.dat, o.err); end
    vec++; if (o.after !== 32'hDEADBEEF) begin
      miss++; $display("FAIL lw_hold got %h exp deadbeef", o.after); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  sz [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] rd [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h0000007F, 32'h12348001};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F, 32'hFFFF8001};
    logic [3:0]  be [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001, 4'b0011};
    obs_t o;
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, sz[i], ad[i], 32'h0, 0, 0, rd[i], o);
      vec++; if (o.dat !== ex[i] || o.valid != 1) begin
        miss++; $display("FAIL load_ext[%0d] got data=%h valid=%0d exp %h 1", i, o.dat, o.valid, ex[i]); end
      vec++; if (o.be !== be[i] || o.addr !== 32'h100) begin
        miss++; $display("FAIL load_be[%0d] got be=%b addr=%h exp %b 100", i, o.be, o.addr, be[i]); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  sz [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h104};
    logic [31:0] ea [3] = '{32'h100, 32'h100, 32'h104};
    logic [3:0]  eb [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ew [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, sz[i], ad[i], 32'h12345678, 0, 0, 32'hA5A5A5A5, o);
      vec++; if (o.we !== 1'b1 || o.be !== eb[i] || o.wdata !== ew[i] || o.addr !== ea[i]) begin
        miss++; $display("FAIL store_bus[%0d] got we=%b be=%b wdata=%h addr=%h exp 1 %b %h %h",
                         i, o.we, o.be, o.wdata, o.addr, eb[i], ew[i], ea[i]); end
      vec++; if (o.valid != 0 || o.after !== 32'hFFFF8001 || o.stall != 2) begin
        miss++; $display("FAIL store_rf[%0d] got valid=%0d hold=%h stall=%0d exp 0 ffff8001 2",
                         i, o.valid, o.after, o.stall); end
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  sz [4] = '{3'b010, 3'b011, 3'b001, 3'b010};
    logic [31:0] ad [4] = '{32'h102, 32'h100, 32'h101, 32'h103};
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      lsu_req_i = 1'b1; lsu_we_i = we[i]; lsu_size_i = sz[i]; lsu_addr_i = ad[i];
      #1;
      vec++; if (lsu_err_o !== 1'b1 || lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin
        miss++; $display("FAIL illegal[%0d] got err=%b stall=%b req=%b exp 1 0 0",
                         i, lsu_err_o, lsu_stall_req_o, data_req_o); end
      step();
      lsu_req_i = 1'b0;
      #1;
      vec++; if (lsu_err_o !== 1'b0 || data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0) begin
        miss++; $display("FAIL illegal_after[%0d] got err=%b req=%b stall=%b exp 0 0 0",
                         i, lsu_err_o, data_req_o, lsu_stall_req_o); end
    end
  endtask

  task automatic test_delay();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, 3, 2, 32'h0BADF00D, o);
    vec++; if (o.req != 4 || o.stall != 7) begin
      miss++; $display("FAIL delay_timing got req=%0d stall=%0d exp 4 7", o.req, o.stall); end
    vec++; if (o.dat !== 32'h0BADF00D || o.valid != 1 || o.addr !== 32'h200) begin
      miss++; $display("FAIL delay_data got data=%h valid=%0d addr=%h exp 0badf00d 1 200",
                       o.dat, o.valid, o.addr); end
  endtask

  task automatic test_timeout();
    int   n = 0, errc = 0;
    logic st_at = 1'b1, rq_at = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h300;
    step();
    while (n < 30 && errc == 0) begin
      #1;
      n++;
      if (lsu_err_o) begin
        errc = n; st_at = lsu_stall_req_o; rq_at = data_req_o; lsu_req_i = 1'b0;
      end
      step();
    end
    lsu_req_i = 1'b0;
    vec++; if (errc != 16) begin
      miss++; $display("FAIL timeout_cycle got %0d exp 16", errc); end
    vec++; if (st_at !== 1'b0 || rq_at !== 1'b1) begin
      miss++; $display("FAIL timeout_pulse got stall=%b req=%b exp 0 1", st_at, rq_at); end
    #1;
    vec++; if (data_req_o !== 1'b0 || lsu_err_o !== 1'b0 || lsu_stall_req_o !== 1'b0 || lsu_valid_o !== 1'b0) begin
      miss++; $display("FAIL timeout_idle got req=%b err=%b stall=%b valid=%b exp 0 0 0 0",
                       data_req_o, lsu_err_o, lsu_stall_req_o, lsu_valid_o); end
    step();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h108;
    step();
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    #1;
    vec++; if (lsu_stall_req_o !== 1'b1) begin
      miss++; $display("FAIL rmid_resp_stall got %b exp 1", lsu_stall_req_o); end
    reset = 1'b1; lsu_req_i = 1'b0;
    #1;
    vec++; if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0 || lsu_valid_o !== 1'b0 || lsu_data_o !== 32'h0) begin
      miss++; $display("FAIL rmid_reset got req=%b stall=%b valid=%b data=%h exp 0 0 0 0",
                       data_req_o, lsu_stall_req_o, lsu_valid_o, lsu_data_o); end
    step();
    reset = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    #1;
    vec++; if (lsu_valid_o !== 1'b0 || lsu_data_o !== 32'h0 || lsu_stall_req_o !== 1'b0) begin
      miss++; $display("FAIL rmid_late_rvalid got valid=%b data=%h stall=%b exp 0 0 0",
                       lsu_valid_o, lsu_data_o, lsu_stall_req_o); end
    step();
    data_rvalid_i = 1'b0;
    run_txn(1'b0, 3'b010, 32'h10C, 32'h0, 0, 0, 32'h13579BDF, o);
    vec++; if (o.dat !== 32'h13579BDF || o.stall != 2 || o.valid != 1) begin
      miss++; $display("FAIL rmid_next got data=%h stall=%0d valid=%0d exp 13579bdf 2 1", o.dat, o.stall, o.valid); end
  endtask

  task automatic test_back_to_back();
    obs_t a, b;
    run_txn(1'b0, 3'b101, 32'h402, 32'h0, 0, 0, 32'hFEDC1234, a);
    run_txn(1'b0, 3'b000, 32'h401, 32'h0, 0, 0, 32'h0000C300, b);
    vec++; if (a.dat !== 32'h0000FEDC || a.stall != 2) begin
      miss++; $display("FAIL b2b_first got data=%h stall=%0d exp 0000fedc 2", a.dat, a.stall); end
    vec++; if (b.dat !== 32'hFFFFFFC3 || b.stall != 2 || b.be !== 4'b0010) begin
      miss++; $display("FAIL b2b_second got data=%h stall=%0d be=%b exp ffffffc3 2 0010", b.dat, b.stall, b.be); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_illegal();
    test_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
